pipe_skid_reg64: RTL
====================

Name: pipe_skid_reg64

Overview:
- Two-entry elastic pipeline register (skid buffer) between OoO pipeline stages; carries a 64-bit operand/result plus a tag.
- Decouples stages with a valid/ready handshake and sustains 1 transfer/cycle.
- in_ready is registered, so no combinational ready path crosses the stage.
- Synchronous flush drops in-flight entries on mispredict/exception; a saturating stall counter supports performance debug.

Parameters:
- WIDTH, 64, data payload width in bits.
- TAG_W, 6, tag width (ROB/physical-register tag).
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; discards all entries.
- in_valid  input  1  upstream offers an entry.
- in_ready  output  1  stage can accept an entry (registered).
- in_data  input  WIDTH  upstream payload.
- in_tag  input  TAG_W  upstream tag.
- out_valid  output  1  main slot holds a valid entry.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  main slot payload.
- out_tag  output  TAG_W  main slot tag.
- occupancy  output  2  number of valid entries (0..2).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main slot drives out_*; skid slot catches one entry when the main slot is stalled.
- States: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
- Registered outputs: in_ready = (next state != FULL); out_valid = (state != EMPTY).
- Transitions at the posedge, evaluated in priority order:
  - flush=1: go to EMPTY. in_fire and out_fire in the same cycle are ignored. Slot data registers hold their values; contents are don't-care.
  - EMPTY, in_fire: main <= in; go to ONE.
  - ONE, in_fire & out_fire: main <= in; stay in ONE.
  - ONE, in_fire & !out_fire: skid <= in; go to FULL.
  - ONE, !in_fire & out_fire: go to EMPTY.
  - FULL, out_fire: main <= skid; go to ONE. in_ready is 0 in FULL, so no in_fire can occur.
  - Any other case: hold state.
- Latency: an entry accepted in EMPTY appears on out_* in the next cycle. Data order is strictly FIFO.
- Back-to-back: with out_ready held at 1, throughput is 1 entry/cycle and occupancy never exceeds 1.
- Stall recovery: after a FULL state, out_ready=1 drains one entry per cycle. in_ready returns to 1 in the cycle after the first out_fire.
- stall_cnt:
  - Increments when out_valid & !out_ready; holds at 2^CNT_W-1.
  - flush does not clear it; only reset does.
- Reset (reset=0, asynchronous):
  - State goes to EMPTY; out_valid=0; in_ready=1.
  - out_data=0, out_tag=0, skid slot cleared to 0, occupancy=0, stall_cnt=0.
  - All inputs are ignored while reset=0.
  - Reset asserted mid-operation discards both entries immediately, without waiting for clk.
- Protocol assertions (bench-checked):
  - in_valid must not drop while in_ready=0.
  - in_data and in_tag must be stable while in_valid & !in_ready.
  - out_* must remain stable while out_valid & !out_ready.

Decomposition:
- Shared package pipe_pkg holds:
  - the skid_state_t enum: EMPTY, ONE, FULL;
  - default WIDTH and TAG_W constants;
  - the packed payload struct pipe_entry_t {tag, data}.
- One natural sub-module: skid_slot, an enable-loaded register of pipe_entry_t with asynchronous active-low reset to 0. It is instantiated twice (main, skid). Control and the stall counter live in the top module.

Test Plan:
- Reset then single transfer: reset=0 for 2 cycles, then in_valid=1 with data=64'hDEAD_BEEF_0000_0001, tag=5, out_ready=1. Required: out_valid=1 with that data/tag the next cycle, occupancy=1, then EMPTY.
- Streaming: 8 back-to-back entries (data=i, tag=i) with out_ready=1. Required: outputs in order 0..7, one per cycle starting 1 cycle after the first input, in_ready always 1.
- Stall and skid: send A=64'h11, then B=64'h22, with out_ready=0. Required: occupancy=2, in_ready=0, out_data=64'h11 held, stall_cnt increments each cycle. Then out_ready=1: 64'h11 then 64'h22 on consecutive cycles, in_ready=1 after the first out_fire.
- Flush while FULL with in_valid=1 (data=64'h33). Required: next cycle out_valid=0, occupancy=0, in_ready=1; 64'h33 never appears at the output.
- Asynchronous reset mid-stall: in FULL, pulse reset=0 between clock edges. Required: out_valid=0, out_data=0, stall_cnt=0 immediately, before the next edge.
- Counter saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles. Required: stall_cnt stops at 15; a subsequent flush leaves it at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the two-entry skid pipeline register: occupancy state and payload entry.
package pipe_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_TAG_W = 6;

  // Encoding equals the number of valid entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_WIDTH-1:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/skid_slot.sv
// Enable-loaded storage for one pipeline entry; clears to zero on reset.
module skid_slot
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  pipe_entry_t d,
  output pipe_entry_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg64.sv
// Two-entry elastic pipeline register with registered in_ready, synchronous flush
// and a saturating downstream-stall counter.
module pipe_skid_reg64
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  skid_state_t state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        in_fire, out_fire;
  logic        main_load, skid_load, main_from_skid;
  pipe_entry_t in_entry, main_d, main_q, skid_q;
  logic [CNT_W-1:0] cnt_q;

  assign in_entry.tag  = in_tag;
  assign in_entry.data = in_data;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path can fire.
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
    main_d     = main_from_skid ? skid_q : in_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  skid_slot u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  skid_slot u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_entry),
    .q     (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q.data;
  assign out_tag   = main_q.tag;
  assign occupancy = state_q;
  assign stall_cnt = cnt_q;

endmodule
